// File: rtl/i2c_slave_regfile.sv
// I2C slave fronting a bank of NUM_REGS byte registers with an auto-incrementing
// pointer; the first written byte of a transfer selects the register.
module i2c_slave_regfile #(
   parameter int         FILTER_LEN = 4,
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         NUM_REGS   = 8,
   localparam int        PTR_W      = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl_i,
   output logic                  scl_o,
   output logic                  scl_t,
   input  logic                  sda_i,
   output logic                  sda_o,
   output logic                  sda_t,
   output logic [NUM_REGS*8-1:0] reg_out,
   output logic                  wr_strobe,
   output logic [PTR_W-1:0]      wr_addr,
   output logic                  bus_active
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_BYTE,
      S_WR_ACK,
      S_RD_BYTE,
      S_RD_ACK,
      S_IGNORE
   } state_t;

   // Index 0 carries SCL, index 1 carries SDA through identical filters so
   // their relative timing is preserved for START/STOP detection.
   logic [1:0] raw_in;
   logic [1:0] filt;
   logic [1:0] filt_d_reg;

   assign raw_in = {sda_i, scl_i};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_filt
         logic [1:0]            sync_reg;
         logic [FILTER_LEN-1:0] hist_reg;
         logic                  filt_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sync_reg <= 2'b11;
               hist_reg <= '1;
               filt_reg <= 1'b1;
            end else begin
               sync_reg <= {sync_reg[0], raw_in[gi]};
               hist_reg <= {hist_reg[FILTER_LEN-2:0], sync_reg[1]};
               if (&hist_reg) begin
                  filt_reg <= 1'b1;
               end else if (~|hist_reg) begin
                  filt_reg <= 1'b0;
               end
            end
         end

         assign filt[gi] = filt_reg;
      end
   endgenerate

   logic scl_f, sda_f;
   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_f     = filt[0];
   assign sda_f     = filt[1];
   assign scl_rise  = scl_f & ~filt_d_reg[0];
   assign scl_fall  = ~scl_f & filt_d_reg[0];
   assign start_det = scl_f & filt_d_reg[0] & filt_d_reg[1] & ~sda_f;
   assign stop_det  = scl_f & filt_d_reg[0] & ~filt_d_reg[1] & sda_f;

   state_t           state_reg, state_next;
   logic [3:0]       cnt_reg, cnt_next;
   logic [7:0]       shift_reg, shift_next;
   logic             first_reg, first_next;
   logic [PTR_W-1:0] ptr_reg, ptr_next;
   logic             sda_t_reg, sda_t_next;
   logic             wr_en;
   logic             wr_strobe_reg;
   logic [PTR_W-1:0] wr_addr_reg;
   logic             bus_active_reg;
   logic [7:0]       rd_byte;

   assign rd_byte = reg_out[{ptr_reg, 3'b000} +: 8];

   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
         logic [7:0] data_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               data_reg <= 8'h00;
            end else if (wr_en && ptr_reg == PTR_W'(gi)) begin
               data_reg <= shift_reg;
            end
         end

         assign reg_out[8*gi +: 8] = data_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt_d_reg     <= 2'b11;
         state_reg      <= S_IDLE;
         cnt_reg        <= 4'd0;
         shift_reg      <= 8'h00;
         first_reg      <= 1'b0;
         ptr_reg        <= '0;
         sda_t_reg      <= 1'b1;
         wr_strobe_reg  <= 1'b0;
         wr_addr_reg    <= '0;
         bus_active_reg <= 1'b0;
      end else begin
         filt_d_reg    <= filt;
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         shift_reg     <= shift_next;
         first_reg     <= first_next;
         ptr_reg       <= ptr_next;
         sda_t_reg     <= sda_t_next;
         wr_strobe_reg <= wr_en;
         if (wr_en) begin
            wr_addr_reg <= ptr_reg;
         end
         if (start_det) begin
            bus_active_reg <= 1'b1;
         end else if (stop_det) begin
            bus_active_reg <= 1'b0;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      shift_next = shift_reg;
      first_next = first_reg;
      ptr_next   = ptr_reg;
      sda_t_next = sda_t_reg;
      wr_en      = 1'b0;

      if (start_det) begin
         state_next = S_ADDR;
         cnt_next   = 4'd0;
         first_next = 1'b0;
         sda_t_next = 1'b1;
      end else if (stop_det) begin
         state_next = S_IDLE;
         sda_t_next = 1'b1;
      end else begin
         case (state_reg)
            S_IDLE: ;
            S_ADDR: begin
               if (scl_rise) begin
                  shift_next = {shift_reg[6:0], sda_f};
                  cnt_next   = cnt_reg + 4'd1;
               end else if (scl_fall && cnt_reg == 4'd8) begin
                  if (shift_reg[7:1] == DEV_ADDR) begin
                     state_next = S_ADDR_ACK;
                     sda_t_next = 1'b0;
                  end else begin
                     state_next = S_IGNORE;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_next = 4'd0;
                  if (shift_reg[0]) begin
                     shift_next = rd_byte;
                     sda_t_next = rd_byte[7];
                     state_next = S_RD_BYTE;
                  end else begin
                     sda_t_next = 1'b1;
                     first_next = 1'b1;
                     state_next = S_WR_BYTE;
                  end
               end
            end
            S_WR_BYTE: begin
               if (scl_rise) begin
                  shift_next = {shift_reg[6:0], sda_f};
                  cnt_next   = cnt_reg + 4'd1;
               end else if (scl_fall && cnt_reg == 4'd8) begin
                  sda_t_next = 1'b0;
                  state_next = S_WR_ACK;
                  // First data byte after the address is the register pointer.
                  if (first_reg) begin
                     ptr_next   = shift_reg[PTR_W-1:0];
                     first_next = 1'b0;
                  end else begin
                     wr_en    = 1'b1;
                     ptr_next = ptr_reg + PTR_W'(1);
                  end
               end
            end
            S_WR_ACK: begin
               if (scl_fall) begin
                  sda_t_next = 1'b1;
                  cnt_next   = 4'd0;
                  state_next = S_WR_BYTE;
               end
            end
            S_RD_BYTE: begin
               if (scl_fall) begin
                  if (cnt_reg == 4'd7) begin
                     sda_t_next = 1'b1;
                     ptr_next   = ptr_reg + PTR_W'(1);
                     cnt_next   = 4'd0;
                     state_next = S_RD_ACK;
                  end else begin
                     shift_next = {shift_reg[6:0], 1'b0};
                     sda_t_next = shift_reg[6];
                     cnt_next   = cnt_reg + 4'd1;
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise && sda_f) begin
                  state_next = S_IGNORE;
               end else if (scl_fall) begin
                  shift_next = rd_byte;
                  sda_t_next = rd_byte[7];
                  cnt_next   = 4'd0;
                  state_next = S_RD_BYTE;
               end
            end
            S_IGNORE: begin
               sda_t_next = 1'b1;
            end
            default: begin
               state_next = S_IDLE;
               sda_t_next = 1'b1;
            end
         endcase
      end
   end

   assign scl_o      = 1'b0;
   assign scl_t      = 1'b1;
   assign sda_o      = 1'b0;
   assign sda_t      = sda_t_reg;
   assign wr_strobe  = wr_strobe_reg;
   assign wr_addr    = wr_addr_reg;
   assign bus_active = bus_active_reg;

endmodule
